// File: rtl/tick_wave_gen.sv
// tick_wave_gen: tick-driven saw/square/triangle sample generator
// with a handshaked config port applied at phase wrap.
// Optional: define TICK_WAVE_GEN_SYNC_EN to add a phase-sync input.
module tick_wave_gen #(
  parameter int PW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
`ifdef TICK_WAVE_GEN_SYNC_EN
  input  logic          sync,
`endif
  input  logic          tick,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_step,
  input  logic [1:0]    cfg_mode,
  input  logic [DW-1:0] cfg_amp,
  output logic [DW-1:0] sample,
  output logic          sample_valid,
  output logic          wrap
);

  typedef enum logic {IDLE, PENDING} st_t;

  st_t           st;
  logic [PW-1:0] phase;
  logic [PW-1:0] step_act;
  logic [1:0]    mode_act;
  logic [DW-1:0] amp_act;
  logic [PW-1:0] step_sh;
  logic [1:0]    mode_sh;
  logic [DW-1:0] amp_sh;

  logic          adv;
  logic [PW:0]   sum;
  logic [PW-1:0] nxt;
  logic          carry;
  logic          apply;
  logic [1:0]    mode_eff;
  logic [DW-1:0] amp_eff;
  logic [DW-1:0] tri_t;
  logic [DW-1:0] raw;
  logic [DW:0]   amp_p1;
  logic [2*DW:0] prod;
  logic [DW-1:0] scaled;

  assign cfg_ready = (st == IDLE);
  assign adv = tick && en;

  // Next phase, carry and config-apply decision for this edge.
  always_comb begin
    sum   = {1'b0, phase} + {1'b0, step_act};
    nxt   = sum[PW-1:0];
    carry = sum[PW];
`ifdef TICK_WAVE_GEN_SYNC_EN
    if (sync) begin
      nxt   = '0;
      carry = 1'b1;
    end
`endif
    apply = (st == PENDING) &&
            (!en || (adv && (carry || step_act == '0)));
    mode_eff = apply ? mode_sh : mode_act;
    amp_eff  = apply ? amp_sh : amp_act;
  end

  // Waveform shaping and amplitude scaling of the next phase.
  always_comb begin
    tri_t = nxt[PW-2 -: DW];
    raw   = '0;
    unique case (mode_eff)
      2'b00:   raw = nxt[PW-1 -: DW];
      2'b01:   raw = nxt[PW-1] ? '0 : '1;
      2'b10:   raw = nxt[PW-1] ? ~tri_t : tri_t;
      default: raw = '0;
    endcase
    amp_p1 = {1'b0, amp_eff} + (DW+1)'(1);
    prod   = (2*DW+1)'(raw) * (2*DW+1)'(amp_p1);
    scaled = DW'(prod >> DW);
  end

  // Phase accumulator, config FSM and registered sample outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      phase        <= '0;
      step_act     <= '0;
      mode_act     <= 2'b00;
      amp_act      <= '1;
      step_sh      <= '0;
      mode_sh      <= 2'b00;
      amp_sh       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= adv;
      wrap         <= adv && carry;
      if (adv) begin
        phase  <= nxt;
        sample <= scaled;
      end
      unique case (st)
        IDLE: begin
          if (cfg_valid) begin
            step_sh <= cfg_step;
            mode_sh <= cfg_mode;
            amp_sh  <= cfg_amp;
            st      <= PENDING;
          end
        end
        PENDING: begin
          if (apply) begin
            step_act <= step_sh;
            mode_act <= mode_sh;
            amp_act  <= amp_sh;
            st       <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
